// File: rtl/ram_banked_clr.sv
// Banked word RAM: DEPTH x WIDTH split into BANKS low-bit-interleaved sub-RAMs, with a zero-fill sweep engine.
// Combinational read, synchronous write; the sweep runs after reset and on clear, takes DEPTH cycles, and drops loads.
module ram_banked_clr #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 6,
  parameter int BANK_BITS = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int DEPTH     = 2 ** ADDR_BITS;
  localparam int BANKS     = 2 ** BANK_BITS;
  localparam int WORD_BITS = ADDR_BITS - BANK_BITS;
  localparam int WPB       = 2 ** WORD_BITS;
  localparam int WIDX_BITS = (WORD_BITS > 0) ? WORD_BITS : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (cnt_q == ADDR_BITS'(DEPTH - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      S_IDLE: begin
        // A same-edge load still lands; the sweep then overwrites it.
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == S_CLEAR);

  // The sweep owns the write port: counter address, zero data, load ignored.
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]     wr_dat;
  logic                 wr_en;
  logic [BANK_BITS-1:0] wr_bank, rd_bank;
  logic [WIDX_BITS-1:0] wr_word, rd_word;
  logic [BANKS-1:0]     bank_we;

  assign wr_addr = busy ? cnt_q : address;
  assign wr_dat  = busy ? '0 : in;
  assign wr_en   = busy | load;
  assign wr_bank = wr_addr[BANK_BITS-1:0];
  assign rd_bank = address[BANK_BITS-1:0];
  assign bank_we = wr_en ? (BANKS'(1) << wr_bank) : '0;

  if (WORD_BITS > 0) begin : g_word_idx
    assign wr_word = wr_addr[ADDR_BITS-1:BANK_BITS];
    assign rd_word = address[ADDR_BITS-1:BANK_BITS];
  end else begin : g_word_idx_single
    assign wr_word = '0;
    assign rd_word = '0;
  end

  logic [WIDTH-1:0] bank_rd [BANKS];

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [WPB];

    always_ff @(posedge clock) begin
      if (bank_we[b]) begin
        mem[wr_word] <= wr_dat;
      end
    end

    assign bank_rd[b] = mem[rd_word];
  end

  assign out = busy ? '0 : bank_rd[rd_bank];

endmodule

// File: tb/tb_ram_banked_clr.sv
// Randomised self-checking bench for ram_banked_clr: default 16x64/8-bank instance plus an 8x512/8-bank instance,
// both compared against a plain array model of the memory with sweep-length expectations taken from DEPTH.
module tb_ram_banked_clr;

  localparam int ADEPTH = 64;
  localparam int BDEPTH = 512;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_rst_n, a_load, a_clear, a_busy;
  logic [15:0] a_in, a_out;
  logic [5:0]  a_addr;

  logic        b_rst_n, b_load, b_clear, b_busy;
  logic [7:0]  b_in, b_out;
  logic [8:0]  b_addr;

  ram_banked_clr #(.WIDTH(16), .ADDR_BITS(6), .BANK_BITS(3)) dut_a (
    .clock(clock), .reset_n(a_rst_n), .in(a_in), .load(a_load),
    .address(a_addr), .clear(a_clear), .out(a_out), .busy(a_busy)
  );

  ram_banked_clr #(.WIDTH(8), .ADDR_BITS(9), .BANK_BITS(3)) dut_b (
    .clock(clock), .reset_n(b_rst_n), .in(b_in), .load(b_load),
    .address(b_addr), .clear(b_clear), .out(b_out), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] ma [ADEPTH];
  logic [7:0]  mb [BDEPTH];

  task automatic model_a_zero();
    for (int i = 0; i < ADEPTH; i++) ma[i] = '0;
  endtask

  task automatic a_write(input int addr, input logic [15:0] data);
    @(negedge clock);
    a_addr = 6'(addr); a_in = data; a_load = 1'b1;
    @(negedge clock);
    a_load = 1'b0;
    ma[addr] = data;
  endtask

  task automatic a_read(input int addr, output logic [15:0] v);
    @(negedge clock);
    a_addr = 6'(addr);
    #1;
    v = a_out;
  endtask

  task automatic a_pulse_clear(output logic busy_after);
    @(negedge clock);
    a_clear = 1'b1;
    @(posedge clock);
    #1;
    a_clear = 1'b0;
    busy_after = a_busy;
    model_a_zero();
  endtask

  // Steps through a sweep counting clock edges until busy falls; optional load, clear or reset at a given cycle.
  task automatic a_sweep(input int load_at, input int clear_at, input int rst_at,
                         output int n, output int out_bad,
                         output logic rst_busy, output logic [15:0] rst_out);
    int r;
    r = rst_at;
    n = 0; out_bad = 0; rst_busy = 1'b0; rst_out = 16'hxxxx;
    while (a_busy === 1'b1 && n < 4 * ADEPTH) begin
      a_addr  = 6'($urandom);
      a_load  = (n == load_at);
      a_clear = (n == clear_at);
      if (n == load_at) begin
        a_addr = 6'd10; a_in = 16'hAAAA;
      end
      #1;
      if (a_out !== 16'h0000) out_bad++;
      if (n == r) begin
        a_rst_n = 1'b0;
        #1;
        rst_busy = a_busy;
        rst_out  = a_out;
        @(negedge clock);
        a_rst_n = 1'b1;
        r = -1;
        n = 0;
        continue;
      end
      @(posedge clock);
      #2;
      n++;
    end
    a_load = 1'b0;
    a_clear = 1'b0;
  endtask

  task automatic test_reset();
    int n, bad;
    logic rb;
    logic [15:0] ro, v;
    #1;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", a_busy); end
    checks++;
    if (a_out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", a_out); end
    @(negedge clock);
    a_rst_n = 1'b1;
    model_a_zero();
    a_sweep(-1, -1, -1, n, bad, rb, ro);
    checks++;
    if (n !== ADEPTH) begin errors++; $display("FAIL reset_sweep_len got=%0d exp=%0d", n, ADEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_sweep_out_zero nonzero_cycles=%0d exp=0", bad); end
    for (int i = 0; i < ADEPTH; i++) begin
      a_read(i, v);
      checks++;
      if (v !== ma[i]) begin errors++; $display("FAIL reset_readback addr=%0d got=%h exp=%h", i, v, ma[i]); end
    end
  endtask

  task automatic test_idle_rw();
    int addrs [6] = '{5, 13, 63, 4, 6, 21};
    logic [15:0] v;
    a_write(5, 16'hBEEF);
    a_write(13, 16'h1234);
    a_write(63, 16'h0F0F);
    foreach (addrs[k]) begin
      a_read(addrs[k], v);
      checks++;
      if (v !== ma[addrs[k]]) begin
        errors++; $display("FAIL idle_rw addr=%0d got=%h exp=%h", addrs[k], v, ma[addrs[k]]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [15:0] old;
    old = ma[7];
    @(negedge clock);
    a_addr = 6'd7; a_in = 16'h5555; a_load = 1'b1;
    #1;
    checks++;
    if (a_out !== old) begin errors++; $display("FAIL same_cycle_read got=%h exp=%h", a_out, old); end
    ma[7] = 16'h5555;
    @(negedge clock);
    a_load = 1'b0;
    #1;
    checks++;
    if (a_out !== ma[7]) begin errors++; $display("FAIL next_cycle_read got=%h exp=%h", a_out, ma[7]); end
  endtask

  task automatic test_load_during_clear();
    int n, bad;
    logic rb, b;
    logic [15:0] ro, v;
    a_pulse_clear(b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL ldclr_busy_rise got=%b exp=1", b); end
    a_sweep(3, -1, -1, n, bad, rb, ro);
    checks++;
    if (n !== ADEPTH) begin errors++; $display("FAIL ldclr_sweep_len got=%0d exp=%0d", n, ADEPTH); end
    a_read(10, v);
    checks++;
    if (v !== ma[10]) begin errors++; $display("FAIL ldclr_dropped got=%h exp=%h", v, ma[10]); end
  endtask

  task automatic test_fill_clear();
    int n, bad;
    logic rb, b;
    logic [15:0] ro, v;
    for (int i = 0; i < ADEPTH; i++) a_write(i, 16'(i) ^ 16'h5A5A);
    for (int i = 0; i < ADEPTH; i++) begin
      a_read(i, v);
      checks++;
      if (v !== ma[i]) begin errors++; $display("FAIL fill_read addr=%0d got=%h exp=%h", i, v, ma[i]); end
    end
    a_pulse_clear(b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL fill_busy_rise got=%b exp=1", b); end
    a_sweep(-1, 20, -1, n, bad, rb, ro);
    checks++;
    if (n !== ADEPTH) begin errors++; $display("FAIL fill_sweep_len_second_clear got=%0d exp=%0d", n, ADEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL fill_sweep_out_zero nonzero_cycles=%0d exp=0", bad); end
    for (int i = 0; i < ADEPTH; i++) begin
      a_read(i, v);
      checks++;
      if (v !== ma[i]) begin errors++; $display("FAIL fill_cleared addr=%0d got=%h exp=%h", i, v, ma[i]); end
    end
  endtask

  task automatic test_same_edge();
    int n, bad;
    logic rb;
    logic [15:0] ro, v;
    @(negedge clock);
    a_addr = 6'd2; a_in = 16'h7777; a_load = 1'b1; a_clear = 1'b1;
    @(posedge clock);
    #1;
    a_load = 1'b0; a_clear = 1'b0;
    ma[2] = 16'h7777;
    model_a_zero();
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL same_edge_busy got=%b exp=1", a_busy); end
    a_sweep(-1, -1, -1, n, bad, rb, ro);
    checks++;
    if (n !== ADEPTH) begin errors++; $display("FAIL same_edge_sweep_len got=%0d exp=%0d", n, ADEPTH); end
    a_read(2, v);
    checks++;
    if (v !== ma[2]) begin errors++; $display("FAIL same_edge_overwritten got=%h exp=%h", v, ma[2]); end
  endtask

  task automatic test_reset_mid_sweep();
    int n, bad;
    logic rb, b;
    logic [15:0] ro, v;
    for (int i = 0; i < 8; i++) a_write(i * 9, 16'($urandom));
    a_pulse_clear(b);
    a_sweep(-1, -1, 30, n, bad, rb, ro);
    checks++;
    if (rb !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", rb); end
    checks++;
    if (ro !== 16'h0000) begin errors++; $display("FAIL midrst_out got=%h exp=0000", ro); end
    checks++;
    if (n !== ADEPTH) begin errors++; $display("FAIL midrst_sweep_len got=%0d exp=%0d", n, ADEPTH); end
    for (int i = 0; i < ADEPTH; i++) begin
      a_read(i, v);
      checks++;
      if (v !== ma[i]) begin errors++; $display("FAIL midrst_readback addr=%0d got=%h exp=%h", i, v, ma[i]); end
    end
  endtask

  task automatic test_random();
    int addr;
    logic [15:0] v;
    for (int k = 0; k < 120; k++) begin
      addr = $urandom_range(0, ADEPTH - 1);
      if ($urandom_range(0, 1) == 0) begin
        a_write(addr, 16'($urandom));
      end else begin
        a_read(addr, v);
        checks++;
        if (v !== ma[addr]) begin errors++; $display("FAIL random_read addr=%0d got=%h exp=%h", addr, v, ma[addr]); end
      end
    end
  endtask

  task automatic test_param_sweep();
    int n, bad, addr;
    int fixed [5] = '{0, 511, 503, 510, 7};
    logic [7:0] v;
    @(negedge clock);
    b_rst_n = 1'b1;
    for (int i = 0; i < BDEPTH; i++) mb[i] = '0;
    n = 0; bad = 0;
    while (b_busy === 1'b1 && n < 4 * BDEPTH) begin
      b_addr = 9'($urandom);
      #1;
      if (b_out !== 8'h00) bad++;
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (n !== BDEPTH) begin errors++; $display("FAIL b_sweep_len got=%0d exp=%0d", n, BDEPTH); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b_sweep_out_zero nonzero_cycles=%0d exp=0", bad); end
    @(negedge clock);
    b_addr = 9'd511; b_in = 8'hC3; b_load = 1'b1;
    @(negedge clock);
    b_load = 1'b0;
    mb[511] = 8'hC3;
    for (int k = 0; k < 40; k++) begin
      addr = $urandom_range(0, BDEPTH - 2);
      @(negedge clock);
      b_addr = 9'(addr); b_in = 8'($urandom); b_load = ($urandom_range(0, 1) == 1);
      if (b_load) mb[addr] = b_in;
      @(negedge clock);
      b_load = 1'b0;
    end
    foreach (fixed[k]) begin
      @(negedge clock);
      b_addr = 9'(fixed[k]);
      #1;
      v = b_out;
      checks++;
      if (v !== mb[fixed[k]]) begin errors++; $display("FAIL b_read addr=%0d got=%h exp=%h", fixed[k], v, mb[fixed[k]]); end
    end
    for (int k = 0; k < 30; k++) begin
      addr = $urandom_range(0, BDEPTH - 1);
      @(negedge clock);
      b_addr = 9'(addr);
      #1;
      checks++;
      if (b_out !== mb[addr]) begin errors++; $display("FAIL b_random_read addr=%0d got=%h exp=%h", addr, b_out, mb[addr]); end
    end
  endtask

  initial begin
    a_rst_n = 1'b1; a_load = 1'b0; a_clear = 1'b0; a_in = '0; a_addr = '0;
    b_rst_n = 1'b1; b_load = 1'b0; b_clear = 1'b0; b_in = '0; b_addr = '0;
    #2;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    #20;
    test_reset();
    test_idle_rw();
    test_read_during_write();
    test_load_during_clear();
    test_fill_clear();
    test_same_edge();
    test_reset_mid_sweep();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_banked_clr.md
Name: ram_banked_clr

Overview:
- Parametrised successor to the fixed 64-word data RAM: DEPTH words of WIDTH bits, built from BANKS interleaved sub-RAMs.
- Adds a hardware zero-fill engine. The array is swept to zero after reset and on demand, with a busy flag exposed to the CPU/memory-map layer.
- Read is combinational and write is synchronous, matching the existing RAM semantics the CPU datapath relies on.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 6, address width; DEPTH = 2**ADDR_BITS words.
- BANK_BITS, 3, log2 of bank count; BANKS = 2**BANK_BITS. Must be ≤ ADDR_BITS.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in  in  WIDTH  write data.
- load  in  1  write enable; sampled on the clock rising edge.
- address  in  ADDR_BITS  word address for both read and write.
- clear  in  1  request a full zero-fill; sampled on the clock rising edge.
- out  out  WIDTH  read data for address.
- busy  out  1  high while the zero-fill is in progress.

Behaviour:
- Address map: bank = address[BANK_BITS-1:0] (low bits, interleaved); word-in-bank = the remaining upper bits.
  - Per-bank write enable comes from a 1-of-BANKS demux of load.
  - out comes from a BANKS-way mux.
- Reset (reset_n=0, asynchronous):
  - state=CLEAR, clear counter=0, busy=1, out=0.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM states:
  - CLEAR:
    - Each cycle: writes 0 to word[counter], then counter++.
    - When the counter is DEPTH-1 that cycle, the final word is written and the next state is IDLE.
    - The sweep takes exactly DEPTH cycles after reset_n rises.
  - IDLE:
    - busy=0.
    - load=1 writes in to word[address] at the clock edge.
    - clear=1 sets the counter to 0 and moves to CLEAR next cycle; busy rises the cycle after clear is sampled.
- During CLEAR:
  - load is ignored; the write is dropped, not queued.
  - out is forced to 0 regardless of address.
  - A clear pulse received during CLEAR is ignored; the sweep does not restart.
- In IDLE, load=1 and clear=1 on the same edge: the write is performed, then the sweep starts next cycle and overwrites it.
- Read timing:
  - In IDLE, out = word[address] combinationally, with no latency.
  - A write is visible on out from the cycle after the edge.
  - Reading the address being written in the same cycle returns the old data.
- Counter width is ADDR_BITS and must not wrap past DEPTH-1 in IDLE.
- Reset asserted mid-sweep: the sweep restarts from 0 on release and again takes DEPTH cycles.
- Reset asserted mid-write: the write is lost and no partial state remains.
- The block is synthesisable with no initial blocks.
- With BANK_BITS=ADDR_BITS, each bank holds 1 word.

Test Plan:
- Release reset_n:
  - busy=1 for exactly 64 cycles, then 0.
  - out=0 during the sweep.
  - Reading every address 0..63 afterwards returns 0x0000.
- IDLE write/read:
  - Write 0xBEEF@5, 0x1234@13 (same bank, bank 5), 0x0F0F@63.
  - Each reads back exactly.
  - The neighbours (4, 6, 21) read 0x0000.
  - Confirms interleave decode and no cross-bank aliasing.
- load=1 during CLEAR (0xAAAA@10 at sweep cycle 3):
  - Dropped; address 10 reads 0x0000 after busy falls.
- Fill all 64 words with address^0x5A5A, then pulse clear:
  - busy rises the next cycle and lasts 64 cycles.
  - All words read 0 afterwards.
  - A second clear pulse at sweep cycle 20 does not extend busy.
- Same-edge load+clear in IDLE (0x7777@2):
  - Sweep starts the next cycle; address 2 reads 0x0000 after busy falls.
- reset_n pulsed low at sweep cycle 30:
  - out=0 and busy=1 immediately.
  - After release, busy lasts a full 64 cycles.
- Parameter sweep: repeat the first two scenarios with WIDTH=8, ADDR_BITS=9, BANK_BITS=3.
  - busy lasts 512 cycles.
  - Write 0xC3@511, read back 0xC3.
